// File: rtl/float_to_int_if.sv
// Handshake bundle for the float-to-int converter: an operand channel
// (in_valid/in_ready/float_in) and a result channel
// (out_valid/out_ready/int_out plus status flags).
interface float_to_int_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int_out;
    logic        overflow;
    logic        invalid;

    modport master (
        output in_valid, float_in, out_ready,
        input  in_ready, out_valid, int_out, overflow, invalid
    );

    modport slave (
        input  in_valid, float_in, out_ready,
        output in_ready, out_valid, int_out, overflow, invalid
    );
endinterface

// File: rtl/float_to_int.sv
// Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter.
// Rounds toward zero. Infinities and out-of-range values saturate. NaN
// returns the integer indefinite value 0x80000000. The mantissa is aligned
// by a one-bit-per-cycle shifter, so latency depends on the exponent.
module float_to_int (
    input  logic          clk,
    input  logic          rst,
    float_to_int_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH,
        DONE
    } state_t;

    state_t             state;
    logic [31:0]        operand;
    logic [31:0]        mag;
    logic [4:0]         k;
    logic               shift_left;
    logic               in_ready_q;
    logic               out_valid_q;
    logic signed [31:0] int_out_q;
    logic               overflow_q;
    logic               invalid_q;

    logic               sign;
    logic [7:0]         exp_f;
    logic [22:0]        mant;
    logic signed [9:0]  e_unb;
    logic signed [9:0]  sh_amt;
    logic [4:0]         k_load;

    // Saturated integer for an out-of-range value of the given sign.
    function automatic logic signed [31:0] saturate(input logic s);
        return s ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    endfunction

    // Two's-complement application of the sign, modulo 2^32.
    function automatic logic signed [31:0] apply_sign(input logic s, input logic [31:0] m);
        logic signed [31:0] sm;
        sm = $signed(m);
        return s ? -sm : sm;
    endfunction

    // Field decode of the captured operand. sh_amt = e - 23 is the
    // distance between the mantissa's binary point and the integer LSB.
    always_comb begin
        sign   = operand[31];
        exp_f  = operand[30:23];
        mant   = operand[22:0];
        e_unb  = $signed({2'b00, exp_f}) - 10'sd127;
        sh_amt = e_unb - 10'sd23;
        k_load = sh_amt[9] ? 5'(-sh_amt) : 5'(sh_amt);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            operand     <= '0;
            mag         <= '0;
            k           <= '0;
            shift_left  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            int_out_q   <= '0;
            overflow_q  <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        operand    <= bus.float_in;
                        overflow_q <= 1'b0;
                        invalid_q  <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= LOAD;
                    end
                end

                LOAD: begin
                    if (exp_f == 8'hFF) begin
                        // NaN reports invalid; infinity saturates.
                        if (mant != '0) begin
                            int_out_q <= 32'sh8000_0000;
                            invalid_q <= 1'b1;
                        end else begin
                            int_out_q  <= saturate(sign);
                            overflow_q <= 1'b1;
                        end
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (e_unb < 10'sd0) begin
                        // Magnitude below one, including zeros and denormals.
                        int_out_q   <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (e_unb >= 10'sd31) begin
                        // -2^31 is the only value with e=31 that fits exactly.
                        if (operand == 32'hCF00_0000) begin
                            int_out_q <= 32'sh8000_0000;
                        end else begin
                            int_out_q  <= saturate(sign);
                            overflow_q <= 1'b1;
                        end
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        mag        <= {8'h00, 1'b1, mant};
                        k          <= k_load;
                        shift_left <= ~sh_amt[9];
                        state      <= (k_load != 5'd0) ? SHIFT : FINISH;
                    end
                end

                SHIFT: begin
                    // Right shifts drop fraction bits, giving truncation toward zero.
                    mag <= shift_left ? (mag << 1) : (mag >> 1);
                    k   <= k - 5'd1;
                    if (k == 5'd1) begin
                        state <= FINISH;
                    end
                end

                FINISH: begin
                    int_out_q   <= apply_sign(sign, mag);
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.int_out   = int_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.invalid   = invalid_q;

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: directed cases, backpressure,
// mid-operation reset and a randomized run against a real-arithmetic model.
module tb_float_to_int;

    logic clk = 1'b0;
    logic rst;
    float_to_int_if bus ();

    float_to_int dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic [31:0] val;
        logic        ovf;
        logic        inv;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;
    bit   force_ready = 1'b1;
    int   last_accept_cyc = 0;
    int   last_consume_cyc = 0;

    // Directed vectors: operand, result, overflow, invalid, latency
    logic [31:0] d_f   [15] = '{32'h4D800000, 32'h4E800001, 32'hC486C000, 32'h3FC00000,
                                32'hBFC00000, 32'h3F000000, 32'h80000000, 32'h7FC00000,
                                32'h7F800000, 32'hFF800000, 32'h4F32D05E, 32'hCF000000,
                                32'h00000001, 32'h4EFFFFFF, 32'hCEFFFFFF};
    logic [31:0] d_val [15] = '{32'h10000000, 32'h40000080, 32'hFFFFFBCA, 32'h00000001,
                                32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h80000000,
                                32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                                32'h00000000, 32'h7FFFFF80, 32'h80000080};
    logic        d_ovf [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    logic        d_inv [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int          d_lat [15] = '{7, 9, 15, 25, 25, 1, 1, 1, 1, 1, 1, 1, 1, 9, 9};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value of the float in real arithmetic, truncated toward zero,
    // saturated outside the int32 range.
    function automatic void ref_model(input logic [31:0] f, output logic [31:0] val,
                                      output logic ovf, output logic inv, output int lat);
        int  ex;
        int  mant;
        real r;
        real lim;
        ex   = int'(f[30:23]);
        mant = int'(f[22:0]);
        lim  = 2147483648.0;
        ovf  = 1'b0;
        inv  = 1'b0;
        lat  = 1;
        val  = '0;
        if (ex == 255) begin
            if (mant != 0) begin
                inv = 1'b1;
                val = 32'h80000000;
            end else begin
                ovf = 1'b1;
                val = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
            end
            return;
        end
        if (ex == 0) r = real'(mant) * (2.0 ** (-149.0));
        else         r = real'(mant + 8388608) * (2.0 ** real'(ex - 150));
        if (f[31]) r = -r;
        if (r >= lim) begin
            ovf = 1'b1;
            val = 32'h7FFFFFFF;
        end else if (r < -lim) begin
            ovf = 1'b1;
            val = 32'h80000000;
        end else begin
            val = $rtoi(r);
            if ((r > -1.0 && r < 1.0) || r == -lim) lat = 1;
            else lat = ((ex > 150) ? (ex - 150) : (150 - ex)) + 2;
        end
    endfunction

    // Present an operand until accepted; push the expectation at acceptance.
    task automatic send(input logic [31:0] f, input logic [31:0] val, input logic ovf,
                        input logic inv, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.float_in = f;
        n = 0;
        while (!bus.in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=in_ready 0 required=1 for %h", f);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.f       = f;
        e.val     = val;
        e.ovf     = ovf;
        e.inv     = inv;
        e.lat     = lat;
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        last_accept_cyc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.float_in = $urandom;
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Consumer ready generator, changing just after each rising edge.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // Monitor: pops and compares on each new result; checks hold/handshake rules.
    initial begin
        logic        prev_valid;
        logic        prev_ready;
        logic [31:0] held_val;
        logic        held_ovf;
        logic        held_inv;
        exp_t        cur;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        held_val   = '0;
        held_ovf   = 1'b0;
        held_inv   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                    if (!prev_valid) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result actual=%h required=no result", bus.int_out);
                        end else begin
                            cur = exp_q.pop_front();
                            check($sformatf("int_out[%h]", cur.f), bus.int_out, cur.val);
                            check($sformatf("overflow[%h]", cur.f), 32'(bus.overflow), 32'(cur.ovf));
                            check($sformatf("invalid[%h]", cur.f), 32'(bus.invalid), 32'(cur.inv));
                            check($sformatf("latency[%h]", cur.f), 32'(cyc - cur.acc_cyc), 32'(cur.lat));
                        end
                        held_val = bus.int_out;
                        held_ovf = bus.overflow;
                        held_inv = bus.invalid;
                    end else if (!prev_ready) begin
                        check("hold_int_out", bus.int_out, held_val);
                        check("hold_overflow", 32'(bus.overflow), 32'(held_ovf));
                        check("hold_invalid", 32'(bus.invalid), 32'(held_inv));
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL done_not_released actual=out_valid 1 required=0");
                    end
                    if (bus.out_ready) last_consume_cyc = cyc + 1;
                end
                prev_valid = bus.out_valid;
                prev_ready = bus.out_ready;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] f;
        logic [31:0] v;
        logic        o;
        logic        iv;
        int          l;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.float_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_int_out", bus.int_out, 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        check("reset_invalid", 32'(bus.invalid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors with an always-ready consumer
        for (int i = 0; i < 15; i++) begin
            send(d_f[i], d_val[i], d_ovf[i], d_inv[i], d_lat[i]);
            idle_cycles(1);
            drain(100);
        end

        // Backpressure followed by a back-to-back operand
        force_ready = 1'b0;
        send(32'h4D800000, 32'h10000000, 1'b0, 1'b0, 7);
        idle_cycles(1);
        l = 0;
        while (!bus.out_valid && l < 50) begin
            @(negedge clk);
            l++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        force_ready = 1'b1;
        send(32'hC486C000, 32'hFFFFFBCA, 1'b0, 1'b0, 15);
        check("bp_accept_gap", 32'(last_accept_cyc - last_consume_cyc), 32'd1);
        idle_cycles(1);
        drain(100);

        // Reset in the middle of the shift phase
        send(32'h3FC00000, 32'h00000001, 1'b0, 1'b0, 25);
        idle_cycles(1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_int_out", bus.int_out, 32'd0);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        check("midrst_invalid", 32'(bus.invalid), 32'd0);
        idle_cycles(30);
        send(32'h4D800000, 32'h10000000, 1'b0, 1'b0, 7);
        idle_cycles(1);
        drain(100);

        // Randomized operands with random gaps and consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            f = $urandom;
            ref_model(f, v, o, iv, l);
            send(f, v, o, iv, l);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 Parameters: none; all widths are fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  float_in holds a valid operand.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 float_in  input  32  IEEE-754 single-precision operand: sign[31], exp[30:23], mant[22:0].
REQ-007 out_valid  output  1  int_out and the flags are valid; high only in DONE.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 int_out  output  32  two's-complement signed integer result, truncated toward zero.
REQ-010 overflow  output  1  the result was saturated (infinity or magnitude at or above 2^31).
REQ-011 invalid  output  1  the operand was NaN.

Function
REQ-012 FSM states are IDLE, LOAD, SHIFT, FINISH and DONE; exactly one state is active at a time.
REQ-013 IDLE: in_ready=1. When in_valid=1 at a clock edge, float_in is captured and the state moves to LOAD.
REQ-014 LOAD decodes the operand, with e = exp-127:
- exp=255, mant!=0: int_out=0x80000000, invalid=1 -> DONE.
- exp=255, mant=0: saturate (sign 0 -> 0x7FFFFFFF, sign 1 -> 0x80000000), overflow=1 -> DONE.
- e<0, including zero and denormals: int_out=0 -> DONE.
- e>=31: saturate as for infinity with overflow=1, except 0xCF000000, which gives 0x80000000 with overflow=0 -> DONE.
- Otherwise: magnitude register = {1'b1, mant} zero-extended to 32 bits; k = |e-23|; direction = left if e>23, else right. Next state is SHIFT if k>0, else FINISH.
REQ-015 SHIFT: each cycle, shift the magnitude one bit in the given direction and decrement k. Bits shifted out on the right are discarded (truncation). Move to FINISH in the cycle k reaches 0.
REQ-016 FINISH: int_out = sign ? -magnitude : magnitude, modulo 2^32 -> DONE.
REQ-017 DONE: out_valid=1. int_out, overflow and invalid are held stable until out_valid and out_ready are both high at an edge; the state then moves to IDLE.
REQ-018 Latency from the accept edge to out_valid high:
- k+2 cycles for normal operands (maximum 25, at e=0).
- 1 cycle for special, zero and saturating operands.
REQ-019 No new operand is accepted before the current result is consumed; in_valid is ignored outside IDLE.
REQ-020 Flags: overflow and invalid are cleared on each accept. At most one of them is set per result.
REQ-021 -0.0 (0x80000000) gives int_out=0 with no flags set.
REQ-022 out_ready is ignored outside DONE; a result never completes early.

Reset
REQ-023 rst=1 at a clock edge forces state=IDLE, in_ready=1, out_valid=0, int_out=0, overflow=0, invalid=0, and clears all internal registers.
REQ-024 rst takes priority over every handshake. Reset mid-operation (LOAD, SHIFT, FINISH or DONE) discards the operand; no out_valid is produced for it.
REQ-025 The first operand after reset deasserts is accepted at the first edge with in_valid=1.

Verification
REQ-026 Normal operands, out_ready=1:
- 0x4D800000 -> 0x10000000, 7 cycles after accept.
- 0x4E800001 -> 0x40000080, 9 cycles.
- 0xC486C000 -> 0xFFFFFBCA (-1078), 15 cycles.
REQ-027 Truncation:
- 0x3FC00000 (1.5) -> 0x00000001, 25 cycles.
- 0xBFC00000 (-1.5) -> 0xFFFFFFFF.
- 0x3F000000 (0.5) -> 0x00000000, 1 cycle.
- 0x80000000 -> 0x00000000, no flags.
REQ-028 Specials:
- 0x7FC00000 -> 0x80000000, invalid=1.
- 0x7F800000 -> 0x7FFFFFFF, overflow=1.
- 0xFF800000 -> 0x80000000, overflow=1.
- 0x4F32D05E (about 3e9) -> 0x7FFFFFFF, overflow=1.
- 0xCF000000 -> 0x80000000, overflow=0.
REQ-029 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, int_out is stable and in_ready stays 0. Raise out_ready -> IDLE on the next edge, and a back-to-back operand is accepted one cycle later.
REQ-030 Reset mid-SHIFT: pulse rst while processing 0x3FC00000 -> all outputs return to reset values on the next edge and no result appears. The next operand, 0x4D800000, produces 0x10000000 with normal latency.
REQ-031 A scoreboard compares every result against a reference model of truncate-toward-zero with saturation, over 10,000 random 32-bit patterns with random in_valid/out_ready; zero mismatches and no handshake violations are required.
